// File: rtl/sc_pkg.sv
// -----------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic-stream to binary converter.
//   sc_state_t    : converter FSM state encoding
//   sc_window_len : window length in cycles for a given log2 window size
// -----------------------------------------------------------------------------
package sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } sc_state_t;

    localparam int unsigned SC_WINDOW_LOG2_MIN = 1;
    localparam int unsigned SC_WINDOW_LOG2_MAX = 16;

    function automatic int unsigned sc_window_len(input int unsigned log2);
        return 32'd1 << log2;
    endfunction

endpackage

// File: rtl/sc_counter.sv
// -----------------------------------------------------------------------------
// sc_counter
// Up-counter with synchronous clear and count enable.
// Ports:
//   clk    : clock, rising edge
//   rst_b  : asynchronous active-low reset, clears count
//   clr    : synchronous clear, wins over en
//   en     : increment by one when high
//   count  : current count value
// -----------------------------------------------------------------------------
module sc_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sc_stream_to_binary.sv
// -----------------------------------------------------------------------------
// sc_stream_to_binary
// Counts the ones in a stochastic bitstream over a window of 2^WINDOW_LOG2
// cycles and presents the count with a valid/ready handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start, value reads 0
// ST_COUNT | sampling bit_in for 2^WINDOW_LOG2 cycles, busy high
// ST_DONE  | holding result on value with out_valid until out_ready
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bit_in    : stochastic bitstream
//   start     : request a conversion window (honoured in IDLE, or DONE+ack)
//   abort     : synchronous cancel, highest priority
//   out_ready : consumer accepts the result
//   busy      : high while counting
//   out_valid : high while a result is held
//   value     : ones count of the last window, 0 otherwise
// -----------------------------------------------------------------------------
module sc_stream_to_binary
    import sc_pkg::*;
#(
    parameter int WINDOW_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bit_in,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   out_valid,
    output logic [WINDOW_LOG2:0]   value
);

    localparam int CW = WINDOW_LOG2 + 1;
    localparam logic [WINDOW_LOG2-1:0] LAST_CYC =
        WINDOW_LOG2'(sc_window_len(WINDOW_LOG2) - 1);

    sc_state_t               state;
    logic [CW-1:0]           ones_q;
    logic [WINDOW_LOG2-1:0]  cyc_q;
    logic                    win_start;
    logic                    cnt_clr;
    logic                    in_count;
    logic                    last_sample;
    logic                    ones_en;

    always_comb begin
        in_count    = (state == ST_COUNT);
        win_start   = !abort && start &&
                      ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
        cnt_clr     = abort || win_start;
        last_sample = in_count && (cyc_q == LAST_CYC);
        ones_en     = in_count && bit_in;
    end

    sc_counter #(.WIDTH(CW)) u_ones_cnt (
        .clk   (clk),
        .rst_b (rst),
        .clr   (cnt_clr),
        .en    (ones_en),
        .count (ones_q)
    );

    // The cycle counter rolls over on the last sample; harmless, since every
    // new window clears it first.
    sc_counter #(.WIDTH(WINDOW_LOG2)) u_cyc_cnt (
        .clk   (clk),
        .rst_b (rst),
        .clr   (cnt_clr),
        .en    (in_count),
        .count (cyc_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            value     <= '0;
        end else if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            value     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_COUNT;
                        busy  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (last_sample) begin
                        // Last sample is folded in here rather than waiting
                        // for the counter, so DONE lands on the next cycle.
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        value     <= ones_q + CW'(bit_in);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        value     <= '0;
                        if (start) begin
                            state <= ST_COUNT;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    value     <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/sc_stream_to_binary.md
SC_STREAM_TO_BINARY -- requirements
Module: sc_stream_to_binary

Interface
REQ-001 The block SHALL have parameter WINDOW_LOG2, default 4, giving a window length of 2^WINDOW_LOG2 cycles (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port bit_in, input, 1, the stochastic bitstream from the upstream adder chain (sum).
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a conversion window.
REQ-006 The block SHALL have port abort, input, 1, synchronous cancel of any conversion.
REQ-007 The block SHALL have port out_ready, input, 1, consumer acceptance of the result.
REQ-008 The block SHALL have port busy, output, 1, high in COUNT.
REQ-009 The block SHALL have port out_valid, output, 1, high in DONE.
REQ-010 The block SHALL have port value, output, WINDOW_LOG2+1, count of ones in the last window (0..2^WINDOW_LOG2).

Function
REQ-011 The block SHALL implement three states: IDLE, COUNT, DONE.
REQ-012 In IDLE, start=1 SHALL move to COUNT next cycle, clearing the ones counter and the cycle counter; bit_in on the start cycle SHALL NOT be counted.
REQ-013 In COUNT, the block SHALL sample bit_in on each of exactly 2^WINDOW_LOG2 consecutive cycles, incrementing the ones counter when bit_in=1.
REQ-014 On the cycle after the last sample, the block SHALL enter DONE with value equal to the final ones count; latency from start to out_valid SHALL be 2^WINDOW_LOG2+1 cycles.
REQ-015 The ones counter SHALL be WINDOW_LOG2+1 bits and SHALL NOT wrap; all-ones input SHALL yield exactly 2^WINDOW_LOG2.
REQ-016 In DONE, out_valid and value SHALL stay stable until a cycle with out_ready=1.
REQ-017 In DONE, out_ready=1 with start=0 SHALL return to IDLE; out_ready=1 with start=1 SHALL go directly to COUNT (back-to-back window, counters cleared).
REQ-018 start SHALL be ignored in COUNT, and in DONE when out_ready=0.
REQ-019 abort=1 in any state SHALL force IDLE next cycle, discard the partial count and clear value to 0; abort SHALL take priority over start and out_ready.
REQ-020 value SHALL read 0 in IDLE and COUNT except when holding a result in DONE.
REQ-021 busy and out_valid SHALL never be high simultaneously.

Reset
REQ-022 rst=0 SHALL immediately, regardless of clk, force IDLE, busy=0, out_valid=0, value=0, and clear both counters.
REQ-023 Reset asserted mid-COUNT or in DONE SHALL discard the conversion; after release, the block SHALL wait for a new start.

Structure
REQ-024 State encoding (IDLE/COUNT/DONE) and the window-length helper constant SHALL live in shared package sc_pkg.
REQ-025 The ones counter and cycle counter SHALL be instances of one sub-module, sc_counter (parameterised width, sync clear, enable, async active-low reset).
REQ-026 The block SHALL contain no combinational path from bit_in to any output.

Verification
REQ-027 WINDOW_LOG2=4, bit_in held 1, start pulse -> out_valid after 17 cycles, value=16, busy high for 16 cycles.
REQ-028 bit_in alternating 1,0 from the first counted cycle -> value=8; bit_in held 0 -> value=0.
REQ-029 Result ready, out_ready held 0 for 5 cycles -> value and out_valid unchanged throughout; out_ready=1 -> IDLE next cycle.
REQ-030 In DONE, out_ready=1 and start=1 in the same cycle -> COUNT next cycle, busy=1, second window count independent of the first.
REQ-031 abort asserted at COUNT cycle 7 with start also high -> IDLE next cycle, value=0, out_valid never asserted.
REQ-032 rst driven low mid-COUNT between clock edges -> outputs 0 immediately; after release, no out_valid until a new start.
